// File: rtl/huffman_frame_ctrl.sv
// Frame sequencer for huffman_encoder_v5: feeds one frame of source words into the
// encoder, closes the statistics window, marks the final word, then drains the
// encoder output FIFO through a small skid buffer into a valid/ready sink.
module huffman_frame_ctrl #(
    parameter logic [31:0] STAT_LEN   = 32'd8192,
    parameter int unsigned SKID_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        go,
    input  logic [31:0] frame_len,
    input  logic [31:0] src_data,
    input  logic        src_valid,
    output logic        src_ready,
    output logic        enc_clean,
    output logic        enc_start,
    output logic [31:0] enc_in_data,
    output logic        enc_in_valid,
    output logic [2:0]  enc_last_mask,
    output logic        enc_stat_end,
    output logic        enc_in_end,
    input  logic        enc_in_full,
    input  logic        enc_done,
    output logic        enc_out_en,
    input  logic [31:0] enc_out_data,
    input  logic        enc_out_valid,
    input  logic        enc_out_empty,
    input  logic        enc_out_hfull,
    output logic [31:0] snk_data,
    output logic        snk_valid,
    input  logic        snk_ready,
    output logic        busy,
    output logic [31:0] hdr_len,
    output logic        hdr_len_valid
);
    localparam int unsigned PtrW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(SKID_DEPTH + 1);

    typedef enum logic [2:0] {
        StIdle, StClean, StStart, StFeed, StWaitDone, StFlush, StHdr
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     len_q, len_d;
    logic [31:0]     sent_q, sent_d;
    logic            stat_q, stat_d;
    logic            end_q, end_d;
    logic [2:0]      mask_q, mask_d;
    logic [CntW-1:0] infl_q, infl_d;
    logic [CntW-1:0] skid_cnt_q, skid_cnt_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]     skid_q [SKID_DEPTH];
    logic [31:0]     skid_d [SKID_DEPTH];

    logic            feed, drain, accept, last_word, stat_word, push, pop;
    logic [32:0]     sent_next;
    logic [2:0]      mask_now;
    logic [CntW:0]   occupancy;

    // Datapath strobes and all module outputs
    always_comb begin
        feed      = (state_q == StFeed);
        drain     = feed | (state_q == StWaitDone) | (state_q == StFlush);
        src_ready = feed & ~enc_in_full & ~enc_out_hfull;
        accept    = src_valid & src_ready;

        // 33-bit sum so a frame near 4 GiB still finds its final word
        sent_next = {1'b0, sent_q} + 33'd4;
        last_word = sent_next >= {1'b0, len_q};
        // Final word always satisfies the first term when frame_len > STAT_LEN
        stat_word = (sent_next >= {1'b0, STAT_LEN}) | last_word;
        // sent is a multiple of 4 and the remainder is 1..4, so 3 bits suffice
        mask_now  = len_q[2:0] - sent_q[2:0];

        enc_in_valid  = accept;
        enc_in_data   = accept ? src_data : '0;
        enc_stat_end  = stat_q | (accept & stat_word);
        enc_in_end    = end_q | (accept & last_word);
        enc_last_mask = (accept & last_word) ? mask_now : mask_q;
        enc_clean     = (state_q == StClean);
        enc_start     = (state_q == StStart);
        busy          = (state_q != StIdle);
        hdr_len       = len_q;
        hdr_len_valid = (state_q == StHdr);

        // Reads already issued count against skid space so the skid cannot overflow
        occupancy  = {1'b0, skid_cnt_q} + {1'b0, infl_q};
        enc_out_en = drain & ~enc_out_empty & (occupancy < (CntW + 1)'(SKID_DEPTH));
        // Only words this block requested are accepted; stale ones after a reset are dropped
        push       = enc_out_valid & (infl_q != '0);
        snk_valid  = (skid_cnt_q != '0);
        snk_data   = snk_valid ? skid_q[rd_ptr_q] : '0;
        pop        = snk_valid & snk_ready;
    end

    // Skid buffer and in-flight read bookkeeping
    always_comb begin
        skid_d     = skid_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        infl_d     = infl_q + CntW'(enc_out_en) - CntW'(push);
        skid_cnt_d = skid_cnt_q + CntW'(push) - CntW'(pop);
        if (push) begin
            skid_d[wr_ptr_q] = enc_out_data;
            wr_ptr_d = (wr_ptr_q == PtrW'(SKID_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(SKID_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    // Frame sequencing FSM
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        sent_d  = sent_q;
        stat_d  = stat_q;
        end_d   = end_q;
        mask_d  = mask_q;
        unique case (state_q)
            StIdle: begin
                if (go && frame_len != '0) begin
                    state_d = StClean;
                    len_d   = frame_len;
                end
            end
            StClean: begin
                state_d = StStart;
                sent_d  = '0;
                stat_d  = 1'b0;
                end_d   = 1'b0;
                mask_d  = '0;
            end
            StStart: state_d = StFeed;
            StFeed: begin
                if (accept) begin
                    sent_d = sent_next[31:0];
                    if (stat_word) stat_d = 1'b1;
                    if (last_word) begin
                        end_d   = 1'b1;
                        mask_d  = mask_now;
                        state_d = StWaitDone;
                    end
                end
            end
            StWaitDone: begin
                if (enc_done) state_d = StFlush;
            end
            StFlush: begin
                if (enc_out_empty && infl_q == '0 && skid_cnt_q == '0) begin
                    state_d = StHdr;
                    stat_d  = 1'b0;
                    end_d   = 1'b0;
                    mask_d  = '0;
                end
            end
            StHdr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q    <= StIdle;
            len_q      <= '0;
            sent_q     <= '0;
            stat_q     <= 1'b0;
            end_q      <= 1'b0;
            mask_q     <= '0;
            infl_q     <= '0;
            skid_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            skid_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            sent_q     <= sent_d;
            stat_q     <= stat_d;
            end_q      <= end_d;
            mask_q     <= mask_d;
            infl_q     <= infl_d;
            skid_cnt_q <= skid_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            skid_q     <= skid_d;
        end
    end

endmodule

// File: tb/tb_huffman_frame_ctrl.sv
// Self-checking bench for huffman_frame_ctrl: a behavioural encoder with an output
// FIFO, random source/sink traffic, and per-frame checks against expectations
// computed from frame length arithmetic.
`timescale 1ns/1ps
module tb_huffman_frame_ctrl;
    localparam logic [31:0] StatLen    = 32'd8192;
    localparam int unsigned SkidDepth  = 2;
    localparam int          HfullLevel = 16;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        go = 1'b0;
    logic [31:0] frame_len = '0;
    logic [31:0] src_data = '0;
    logic        src_valid = 1'b0;
    logic        src_ready;
    logic        enc_clean, enc_start, enc_in_valid, enc_stat_end, enc_in_end;
    logic [31:0] enc_in_data;
    logic [2:0]  enc_last_mask;
    logic        enc_in_full = 1'b0;
    logic        enc_done = 1'b0;
    logic        enc_out_en;
    logic [31:0] enc_out_data = '0;
    logic        enc_out_valid = 1'b0;
    logic        enc_out_empty = 1'b1;
    logic        enc_out_hfull = 1'b0;
    logic [31:0] snk_data;
    logic        snk_valid;
    logic        snk_ready = 1'b1;
    logic        busy;
    logic [31:0] hdr_len;
    logic        hdr_len_valid;

    always #5 clk = ~clk;

    huffman_frame_ctrl #(
        .STAT_LEN  (StatLen),
        .SKID_DEPTH(SkidDepth)
    ) dut (
        .clk          (clk),
        .rstN         (rstN),
        .go           (go),
        .frame_len    (frame_len),
        .src_data     (src_data),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .enc_clean    (enc_clean),
        .enc_start    (enc_start),
        .enc_in_data  (enc_in_data),
        .enc_in_valid (enc_in_valid),
        .enc_last_mask(enc_last_mask),
        .enc_stat_end (enc_stat_end),
        .enc_in_end   (enc_in_end),
        .enc_in_full  (enc_in_full),
        .enc_done     (enc_done),
        .enc_out_en   (enc_out_en),
        .enc_out_data (enc_out_data),
        .enc_out_valid(enc_out_valid),
        .enc_out_empty(enc_out_empty),
        .enc_out_hfull(enc_out_hfull),
        .snk_data     (snk_data),
        .snk_valid    (snk_valid),
        .snk_ready    (snk_ready),
        .busy         (busy),
        .hdr_len      (hdr_len),
        .hdr_len_valid(hdr_len_valid)
    );

    int n_checks = 0;
    int n_errors = 0;
    int sink_mode = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int q_mismatch(input logic [31:0] a[$], input logic [31:0] b[$]);
        int n = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
        for (int i = 0; i < a.size() && i < b.size(); i++) begin
            if (a[i] !== b[i]) n++;
        end
        return n;
    endfunction

    // Behavioural encoder, sink monitor and frame event recorder
    logic [31:0] oq[$];
    logic [31:0] exp_out[$];
    logic [31:0] rx_out[$];
    logic [31:0] rx_in[$];
    logic [31:0] src_exp[$];
    int          cyc = 0;
    int          wcnt = 0, stat_first = 0, end_first = 0;
    logic [2:0]  mask_at_end = '0;
    int          done_timer = 0;
    int          outst = 0, max_outst = 0;
    int          clean_cnt = 0, start_cnt = 0, clean_cyc = 0, start_cyc = 0, busy_cnt = 0;
    int          hdr_cnt = 0, hdr_rx_size = 0;
    logic [31:0] hdr_val = '0;
    int          bad_en = 0, bad_in = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rstN) begin
            oq.delete();
            done_timer    <= 0;
            enc_done      <= 1'b0;
            enc_out_valid <= 1'b0;
            enc_out_data  <= '0;
            enc_out_empty <= 1'b1;
            enc_out_hfull <= 1'b0;
            outst         <= 0;
        end else begin
            if (busy) busy_cnt <= busy_cnt + 1;
            if (enc_start) begin
                start_cnt <= start_cnt + 1;
                start_cyc <= cyc;
            end
            if (enc_out_en) begin
                enc_out_valid <= 1'b1;
                if (oq.size() == 0) begin
                    bad_en       <= bad_en + 1;
                    enc_out_data <= '0;
                end else begin
                    enc_out_data <= oq.pop_front();
                end
            end else begin
                enc_out_valid <= 1'b0;
                enc_out_data  <= '0;
            end
            if (enc_clean) begin
                oq.delete();
                exp_out.delete();
                rx_out.delete();
                rx_in.delete();
                wcnt        <= 0;
                stat_first  <= 0;
                end_first   <= 0;
                mask_at_end <= '0;
                outst       <= 0;
                max_outst   <= 0;
                done_timer  <= 0;
                clean_cnt   <= clean_cnt + 1;
                clean_cyc   <= cyc;
            end else begin
                outst <= outst + (enc_out_en ? 1 : 0) - ((snk_valid && snk_ready) ? 1 : 0);
                if (outst > max_outst) max_outst <= outst;
            end
            if (enc_in_valid) begin
                if (enc_in_full) bad_in <= bad_in + 1;
                rx_in.push_back(enc_in_data);
                oq.push_back(enc_in_data ^ 32'h5A5A_5A5A);
                exp_out.push_back(enc_in_data ^ 32'h5A5A_5A5A);
                wcnt <= wcnt + 1;
                if (enc_stat_end && stat_first == 0) stat_first <= wcnt + 1;
                if (enc_in_end && end_first == 0) begin
                    end_first   <= wcnt + 1;
                    mask_at_end <= enc_last_mask;
                    done_timer  <= 6;
                end
            end
            enc_done <= 1'b0;
            if (done_timer > 0) begin
                done_timer <= done_timer - 1;
                if (done_timer == 1) begin
                    // Trailer word emitted by the encoder when it finishes
                    oq.push_back(32'hE0D0_0000 ^ 32'(cyc));
                    exp_out.push_back(32'hE0D0_0000 ^ 32'(cyc));
                    enc_done <= 1'b1;
                end
            end
            if (snk_valid && snk_ready) rx_out.push_back(snk_data);
            if (hdr_len_valid) begin
                hdr_cnt     <= hdr_cnt + 1;
                hdr_val     <= hdr_len;
                hdr_rx_size <= rx_out.size();
            end
            enc_out_empty <= (oq.size() == 0);
            enc_out_hfull <= (oq.size() >= HfullLevel);
        end
    end

    // Sink ready pattern
    initial begin
        forever begin
            @(negedge clk);
            case (sink_mode)
                0:       snk_ready = 1'b1;
                1:       snk_ready = (cyc % 3 == 0);
                default: snk_ready = ($urandom_range(1) == 1);
            endcase
        end
    end

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_ctrl"}, 64'({busy, src_ready, enc_clean, enc_start, enc_in_valid,
                 enc_stat_end, enc_in_end, enc_last_mask, enc_out_en, snk_valid,
                 hdr_len_valid}), 64'd0);
        check_eq({tag, "_data"}, 64'(enc_in_data | snk_data | hdr_len), 64'd0);
    endtask

    task automatic run_frame(input logic [31:0] len, input int stall_at, input int abort_at);
        int          nwords, idx, budget, stall_left, stall_bad, clean0, hdr0;
        int          exp_stat, exp_mask;
        bit          stall_done;
        logic [31:0] words[$];
        nwords = (int'(len) + 3) / 4;
        exp_stat = (len <= StatLen) ? nwords : (int'(StatLen) + 3) / 4;
        exp_mask = int'(len) - 4 * (nwords - 1);
        src_exp.delete();
        for (int i = 0; i < nwords; i++) words.push_back($urandom);
        clean0 = clean_cnt;
        hdr0   = hdr_cnt;
        @(negedge clk);
        go = 1'b1;
        frame_len = len;
        @(negedge clk);
        go = 1'b0;
        idx = 0; budget = 0; stall_left = 0; stall_bad = 0; stall_done = 0;
        while (idx < nwords && budget < 40000) begin
            if (idx == abort_at) begin
                src_valid = 1'b0;
                rstN = 1'b0;
                @(negedge clk);
                #1;
                check_outputs_zero("abort");
                rstN = 1'b1;
                repeat (30) @(negedge clk);
                check_eq("abort_no_hdr", 64'(hdr_cnt - hdr0), 64'd0);
                return;
            end
            if (idx == stall_at && !stall_done) begin
                stall_left = 20;
                stall_done = 1;
            end
            enc_in_full = (stall_left > 0);
            src_valid = (stall_left > 0) ? 1'b1 : ($urandom_range(3) != 0);
            src_data = words[idx];
            #1;
            if (stall_left > 0) begin
                if (src_ready || enc_in_valid) stall_bad++;
                stall_left--;
            end else if (src_valid && src_ready) begin
                src_exp.push_back(words[idx]);
                idx++;
            end
            @(negedge clk);
            budget++;
        end
        src_valid = 1'b0;
        enc_in_full = 1'b0;
        check_eq("feed_done", 64'(idx), 64'(nwords));
        if (stall_at >= 0) check_eq("stall_block", 64'(stall_bad), 64'd0);
        budget = 0;
        while (hdr_cnt == hdr0 && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        check_eq("hdr_pulse", 64'(hdr_cnt - hdr0), 64'd1);
        check_eq("hdr_len", 64'(hdr_val), 64'(len));
        @(negedge clk);
        #1;
        check_eq("hdr_hold", 64'({busy, hdr_len_valid, hdr_len}), 64'({2'b00, len}));
        check_eq("clean_once", 64'(clean_cnt - clean0), 64'd1);
        check_eq("start_after_clean", 64'(start_cyc - clean_cyc), 64'd1);
        check_eq("in_seq", 64'(q_mismatch(rx_in, src_exp)), 64'd0);
        check_eq("out_seq", 64'(q_mismatch(rx_out, exp_out)), 64'd0);
        check_eq("drained_before_hdr", 64'(hdr_rx_size), 64'(exp_out.size()));
        check_eq("stat_word", 64'(stat_first), 64'(exp_stat));
        check_eq("end_word", 64'(end_first), 64'(nwords));
        check_eq("last_mask", 64'(mask_at_end), 64'(exp_mask));
        check_eq("skid_bound", 64'(max_outst <= int'(SkidDepth)), 64'd1);
        check_eq("proto_viol", 64'(bad_en + bad_in), 64'd0);
    endtask

    initial begin
        int busy0, cs0;
        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("reset");
        rstN = 1'b1;

        sink_mode = 0;
        run_frame(32'd10, -1, -1);
        run_frame(32'd8196, -1, -1);
        run_frame(32'd301, 40, -1);
        sink_mode = 1;
        run_frame(32'd200, -1, -1);
        check_eq("slow_sink_fills_skid", 64'(max_outst), 64'(SkidDepth));

        busy0 = busy_cnt;
        cs0 = clean_cnt + start_cnt;
        @(negedge clk);
        go = 1'b1;
        frame_len = 32'd0;
        @(negedge clk);
        go = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("zero_len_busy", 64'(busy_cnt - busy0), 64'd0);
        check_eq("zero_len_pulses", 64'(clean_cnt + start_cnt - cs0), 64'd0);

        sink_mode = 2;
        run_frame(32'd1000, -1, 100);
        run_frame(32'd4, -1, -1);
        for (int i = 0; i < 6; i++) begin
            sink_mode = i % 3;
            run_frame(32'($urandom_range(64, 1)), -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
